cc_cfg_regs: RTL

CC_CFG_REGS -- requirements
Module: cc_cfg_regs

---
 rtl/cc_cfg_pkg.sv | 13 +
 rtl/cc_sat_cnt.sv | 16 +
 rtl/cc_cfg_regs.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cc_cfg_pkg.sv
// cc_cfg_pkg: register map offsets, APB FSM states and IRQ width for cc_cfg_regs
package cc_cfg_pkg;
    localparam logic [11:0] ADDR_VERSION   = 12'h000;
    localparam logic [11:0] ADDR_CTRL      = 12'h004;
    localparam logic [11:0] ADDR_STATUS    = 12'h008;
    localparam logic [11:0] ADDR_IRQ_STAT  = 12'h00C;
    localparam logic [11:0] ADDR_IRQ_EN    = 12'h010;
    localparam logic [11:0] ADDR_HIT_CNT   = 12'h014;
    localparam logic [11:0] ADDR_MISS_CNT  = 12'h018;
    localparam logic [11:0] ADDR_USER_BASE = 12'h100;
    localparam int IRQ_W = 8;
    typedef enum logic {S_IDLE, S_ACCESS} apb_state_t;
endpackage

// File: rtl/cc_sat_cnt.sv
// cc_sat_cnt: 32-bit saturating event counter with synchronous clear (clear wins)
module cc_sat_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        clr_i,
    output logic [31:0] count_o
);
    logic [31:0] r_count;
    // count up on inc, hold at all-ones, clear overrides everything
    always_ff @(posedge clk) begin
        if (rst || clr_i) r_count <= '0;
        else if (inc_i && r_count != 32'hFFFF_FFFF) r_count <= r_count + 32'd1;
    end
    assign count_o = r_count;
endmodule

// File: rtl/cc_cfg_regs.sv
// cc_cfg_regs: APB config register block; perf counters enabled by CC_CFG_PERF_CNT_EN
module cc_cfg_regs
    import cc_cfg_pkg::*;
#(
    parameter int          NUM_USER    = 4,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] VERSION     = 32'h0003_2025
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [11:0]           paddr_i,
    input  logic [31:0]           pwdata_i,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic [31:0]           prdata_o,
    output logic [31:0]           ctrl_o,
    output logic [32*NUM_USER-1:0] user_o,
    input  logic [31:0]           status_i,
    input  logic [IRQ_W-1:0]      event_i,
    output logic                  irq_o,
    input  logic                  hit_i,
    input  logic                  miss_i
);
    apb_state_t       r_state, w_next;
    logic [3:0]       r_wait;
    logic [11:0]      r_addr;
    logic             r_write;
    logic [31:0]      r_wdata, r_status, r_ctrl;
    logic [31:0]      r_user [NUM_USER];
    logic [IRQ_W-1:0] r_irq_stat, r_irq_en, w_w1c;
    logic             r_irq;
    logic             w_setup, w_ready, w_err, w_commit, w_user_hit;
    logic [4:0]       w_idx;
    logic [31:0]      w_rdata;
`ifdef CC_CFG_PERF_CNT_EN
    logic [31:0]      w_hit_cnt, w_miss_cnt;
`endif

    assign w_setup    = psel_i & ~penable_i;
    assign w_ready    = ~rst & (r_state == S_ACCESS) & (r_wait == 4'd0);
    assign w_idx      = r_addr[6:2];
    assign w_user_hit = r_addr[11:7] == ADDR_USER_BASE[11:7];

    // APB state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    // next state: leave IDLE on setup, return after ready or on psel drop (abort)
    always_comb begin
        w_next = (r_state == S_IDLE) ? (w_setup ? S_ACCESS : S_IDLE)
                                     : ((!psel_i || w_ready) ? S_IDLE : S_ACCESS);
    end

    // capture the setup phase and run the access-phase wait counter
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_setup) begin
            r_addr   <= paddr_i;
            r_write  <= pwrite_i;
            r_wdata  <= pwdata_i;
            r_status <= status_i;
            r_wait   <= 4'(WAIT_CYCLES);
        end else if (r_state == S_ACCESS && r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
        end
    end

    // decode the captured address into read data and an error flag
    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        if (r_addr[1:0] != 2'b00) begin
            w_err = 1'b1;
        end else if (w_user_hit) begin
            w_err = int'(w_idx) >= NUM_USER;
            for (int k = 0; k < NUM_USER; k++) if (w_idx == 5'(k)) w_rdata = r_user[k];
        end else begin
            case (r_addr)
                ADDR_VERSION:  begin w_rdata = VERSION;  w_err = r_write; end
                ADDR_CTRL:     w_rdata = r_ctrl;
                ADDR_STATUS:   begin w_rdata = r_status; w_err = r_write; end
                ADDR_IRQ_STAT: w_rdata = 32'(r_irq_stat);
                ADDR_IRQ_EN:   w_rdata = 32'(r_irq_en);
`ifdef CC_CFG_PERF_CNT_EN
                ADDR_HIT_CNT:  w_rdata = w_hit_cnt;
                ADDR_MISS_CNT: w_rdata = w_miss_cnt;
`endif
                default:       w_err = 1'b1;
            endcase
        end
    end

    assign w_commit  = w_ready & penable_i & psel_i & r_write & ~w_err;
    assign w_w1c     = (w_commit && r_addr == ADDR_IRQ_STAT) ? r_wdata[IRQ_W-1:0] : '0;
    assign pready_o  = w_ready;
    assign pslverr_o = w_ready & w_err;
    assign prdata_o  = (w_ready & ~w_err) ? w_rdata : '0;
    assign ctrl_o    = r_ctrl;
    assign irq_o     = r_irq;

    // register file updates; an event in the same cycle as a W1C keeps the bit set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl     <= '0;
            r_irq_stat <= '0;
            r_irq_en   <= '0;
            r_irq      <= 1'b0;
            for (int k = 0; k < NUM_USER; k++) r_user[k] <= '0;
        end else begin
            r_irq_stat <= (r_irq_stat & ~w_w1c) | event_i;
            r_irq      <= |(r_irq_stat & r_irq_en);
            if (w_commit && r_addr == ADDR_CTRL) r_ctrl <= r_wdata;
            if (w_commit && r_addr == ADDR_IRQ_EN) r_irq_en <= r_wdata[IRQ_W-1:0];
            for (int k = 0; k < NUM_USER; k++)
                if (w_commit && w_user_hit && w_idx == 5'(k)) r_user[k] <= r_wdata;
        end
    end

    for (genvar g = 0; g < NUM_USER; g++) begin : g_user
        assign user_o[32*g +: 32] = r_user[g];
    end

`ifdef CC_CFG_PERF_CNT_EN
    cc_sat_cnt u_hit_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (hit_i),
        .clr_i   (w_commit && r_addr == ADDR_HIT_CNT),
        .count_o (w_hit_cnt)
    );
    cc_sat_cnt u_miss_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (miss_i),
        .clr_i   (w_commit && r_addr == ADDR_MISS_CNT),
        .count_o (w_miss_cnt)
    );
`else
    logic w_unused_perf;
    assign w_unused_perf = hit_i ^ miss_i;
`endif
endmodule
